// File: rtl/cam_input_rr_arbiter.sv
// Ten-channel camera capture buffers drained round-robin into one channel-tagged valid/ready stream.
// Optional macro CAM_ARB_DROP_CNT_EN adds a saturating drop_total counter output.
module cam_input_rr_arbiter #(
    parameter int NUM_CH = 10,
    parameter int DATA_W = 15,
    parameter int IDX_W  = 4
) (
    input  logic                     clk_clk,
    input  logic                     reset_reset,
    input  logic                     arb_enable,
    input  logic [NUM_CH-1:0]        ch_valid,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [IDX_W-1:0]         out_ch,
    output logic [NUM_CH-1:0]        ch_pending,
    output logic [NUM_CH-1:0]        ovf,
    input  logic                     ovf_clear
`ifdef CAM_ARB_DROP_CNT_EN
    ,
    output logic [15:0]              drop_total
`endif
);

    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   buf_q [NUM_CH];
    logic [DATA_W-1:0]   buf_d [NUM_CH];
    logic [NUM_CH-1:0]   pend_q, pend_d;
    logic [NUM_CH-1:0]   ovf_q, ovf_d;
    logic [NUM_CH-1:0]   cap, ovf_set, gnt_oh;
    logic [IDX_W-1:0]    rr_ptr_q, gnt_idx;
    logic                gnt_found, grant;
    logic                out_valid_q;
    logic [DATA_W-1:0]   out_data_q;
    logic [IDX_W-1:0]    out_ch_q;

    // First pending channel at or after rr_ptr, wrapping past NUM_CH-1.
    always_comb begin : grant_sel
        int unsigned idx;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!gnt_found && pend_q[SEL_W'(idx)]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDX_W'(idx);
            end
        end
    end

    assign grant  = arb_enable && gnt_found && (state_q == IDLE || out_ready);
    assign gnt_oh = grant ? (NUM_CH'(1) << gnt_idx) : '0;

    // A buffer being granted this edge can accept a new word without overflowing.
    always_comb begin
        cap     = '0;
        ovf_set = '0;
        pend_d  = pend_q & ~gnt_oh;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cap[i]     = ch_valid[i] && (!pend_q[i] || gnt_oh[i]);
            ovf_set[i] = ch_valid[i] && pend_q[i] && !gnt_oh[i];
            buf_d[i]   = cap[i] ? ch_data[i*DATA_W +: DATA_W] : buf_q[i];
            if (cap[i]) pend_d[i] = 1'b1;
        end
        ovf_d = (ovf_clear ? '0 : ovf_q) | ovf_set;
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            pend_q <= '0;
            ovf_q  <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) buf_q[i] <= '0;
        end else begin
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
            for (int unsigned i = 0; i < NUM_CH; i++) buf_q[i] <= buf_d[i];
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            if (grant) begin
                out_data_q <= buf_q[SEL_W'(gnt_idx)];
                out_ch_q   <= gnt_idx;
                rr_ptr_q   <= (gnt_idx == IDX_W'(NUM_CH-1)) ? '0 : gnt_idx + 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        out_valid_q <= 1'b1;
                        state_q     <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (out_ready && !grant) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef CAM_ARB_DROP_CNT_EN
    logic [15:0] drop_q;
    logic [16:0] drop_sum;

    assign drop_sum = {1'b0, (ovf_clear ? 16'h0000 : drop_q)} + 17'($countones(ovf_set));

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) drop_q <= '0;
        else             drop_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    assign drop_total = drop_q;
`endif

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_ch     = out_ch_q;
    assign ch_pending = pend_q;
    assign ovf        = ovf_q;

endmodule

// File: doc/cam_input_rr_arbiter.md
Name: cam_input_rr_arbiter

Overview:
- Shares one 15-bit camera-pixel transfer path among ten camera input channels.
- Each channel has a one-word capture buffer. A round-robin scheduler drains the buffers into a single valid/ready output stream, and each word is tagged with its channel index.
- Sits between the per-camera front ends and the processor-side input ports, so the processor sees one serialized stream instead of ten parallel ports.
- Sticky per-channel overflow flags report captures lost to a full buffer.

Parameters:
NUM_CH, 10, number of camera channels (2..16)
DATA_W, 15, pixel word width per channel
IDX_W, 4, channel index width; must satisfy 2^IDX_W >= NUM_CH

Ports:
clk_clk  in  1  single system clock; all logic on rising edge
reset_reset  in  1  asynchronous, active-high reset
arb_enable  in  1  1 = scheduler may issue new grants
ch_valid  in  NUM_CH  per-channel capture strobe, one cycle per word
ch_data  in  NUM_CH*DATA_W  channel i data in bits [i*DATA_W +: DATA_W]
out_valid  out  1  output word valid
out_ready  in  1  downstream accepts when out_valid && out_ready
out_data  out  DATA_W  granted word
out_ch  out  IDX_W  channel index of out_data
ch_pending  out  NUM_CH  buffer-full flags (registered)
ovf  out  NUM_CH  sticky overflow flags
ovf_clear  in  1  one-cycle pulse; clears all ovf bits

Behaviour:
- Reset (asynchronous assert): out_valid=0, out_data=0, out_ch=0, ch_pending=0, ovf=0, rr_ptr=0, state=IDLE.
- Capture, channel i, evaluated at each edge:
  - If ch_valid[i] is high and buffer i is empty, or buffer i is being granted at the same edge: buf[i]<=ch_data slice and pending[i]<=1.
  - Else if ch_valid[i] is high and buffer i is full and not granted: the word is dropped, buf[i] keeps the old word, and ovf[i]<=1.
- Grant selection (combinational):
  - Choose the first index g with pending[g]=1, scanning from rr_ptr upward and wrapping from NUM_CH-1 to 0.
  - A grant occurs only when arb_enable=1 and the FSM permits it. On a grant: rr_ptr<=g+1, or 0 if g=NUM_CH-1; pending[g] clears unless a simultaneous capture refills it.
- FSM:
  - IDLE: if a grant occurs, load out_data=buf[g], out_ch=g, out_valid<=1, go to PRESENT. Otherwise stay.
  - PRESENT, out_ready=0: hold out_data, out_ch and out_valid stable. No grant.
  - PRESENT, out_ready=1: the word is accepted. If a grant is possible in the same cycle, load the next word and stay in PRESENT (back-to-back, one word per clock). Otherwise out_valid<=0 and go to IDLE.
- Latency:
  - Capture at edge N sets pending at N. The earliest out_valid=1 is edge N+1, with the FSM in IDLE.
  - Sustained throughput is 1 word/clock while requests remain.
- arb_enable dropped while in PRESENT: the current word completes its handshake, then the FSM returns to IDLE. Captures and overflow detection continue while disabled.
- ovf_clear together with a new overflow on the same edge: the set wins for that bit; all other bits clear.
- Fairness: with all channels pending, each channel is granted once per NUM_CH accepted words.
- Reset asserted mid-transfer: the in-flight word and all buffered words are discarded. There is no partial state after reset release.

Optional Feature:
- Macro: CAM_ARB_DROP_CNT_EN.
- When defined:
  - Adds output drop_total [15:0], a saturating count of all dropped captures.
  - Increments by the popcount of overflow events at each edge and saturates at 16'hFFFF.
  - Reset and ovf_clear set it to 0. If ovf_clear and drops occur on the same edge, the result equals that edge's popcount.
- When not defined: the port and counter logic are absent. All other behaviour is identical.

Test Plan:
- Single request: reset, arb_enable=1, out_ready=1, ch_valid[3] with data 15'h1234 at edge 5 -> out_valid=1, out_data=15'h1234, out_ch=3 at edge 6; out_valid=0 at edge 7.
- Round robin: all ten channels captured at one edge with data=channel*0x111, out_ready=1 -> out_ch sequence 0..9 on consecutive clocks; then 2 more captures on channels 2 and 7 -> order 2, 7.
- Backpressure: out_ready=0 for 8 cycles while out_valid=1 -> out_data and out_ch stable. A second capture on the same channel during the stall is buffered; a third sets ovf for that channel.
- Refill on grant: channel 4 captures at the same edge its buffer is granted -> no ovf, and the new word appears as a later grant.
- Disable: arb_enable=0 with 3 channels pending -> out_valid stays 0 and ch_pending=3 bits; re-enable -> the words drain in rr_ptr order.
- With CAM_ARB_DROP_CNT_EN: 2 channels overflow on the same edge -> drop_total +2. ovf_clear plus 1 drop on the same edge -> drop_total=1.
